// File: rtl/pipe_pkg.sv
// Shared encodings and default widths for the elastic
// pipeline register and its slot.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  localparam int CTRL_W_EXMEM = 2;
  localparam int DATA_W_EXMEM = 40;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry: valid + resettable ctrl + unreset data.
// Clear wins over load.
module pipe_slot #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = d_ctrl;
      data_d  = d_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // datapath bits are never reset
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with flush and an optional
// 2-entry skid buffer that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_EXMEM,
  parameter int DATA_W = DATA_W_EXMEM,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              in_fire, out_fire;
  logic              main_load, main_clear;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl;
  logic [DATA_W-1:0] main_data_d, main_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_ctrl_d),
    .d_data (main_data_d),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  if (SKID != 0) begin : g_skid
    ps_state_e         state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              skid_load, skid_clear;
    logic              skid_valid, from_skid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_slot #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_skid (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );

    always_comb begin
      state_d    = state_q;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      from_skid  = 1'b0;
      if (flush) begin
        state_d    = PS_EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state_q)
          PS_EMPTY: begin
            if (in_fire) begin
              state_d   = PS_HALF;
              main_load = 1'b1;
            end
          end
          PS_HALF: begin
            unique case ({in_fire, out_fire})
              2'b11: main_load = 1'b1;
              2'b10: begin
                state_d   = PS_FULL;
                skid_load = 1'b1;
              end
              2'b01: begin
                state_d    = PS_EMPTY;
                main_clear = 1'b1;
              end
              default: ;
            endcase
          end
          PS_FULL: begin
            if (out_fire && skid_valid) begin
              state_d    = PS_HALF;
              main_load  = 1'b1;
              from_skid  = 1'b1;
              skid_clear = 1'b1;
            end
          end
          default: state_d = PS_EMPTY;
        endcase
      end
      // ready is decided a cycle early, breaking the stall ripple
      rdy_d       = (state_d != PS_FULL);
      main_ctrl_d = from_skid ? skid_ctrl : in_ctrl;
      main_data_d = from_skid ? skid_data : in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= PS_EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q   <= rdy_d;
      end
    end

    assign in_ready = rdy_q;
    assign count    = state_q;
  end else begin : g_single
    assign in_ready    = ~main_valid | out_ready;
    assign main_load   = in_fire;
    assign main_clear  = flush | (out_fire & ~in_fire);
    assign main_ctrl_d = in_ctrl;
    assign main_data_d = in_data;
    assign count       = {1'b0, main_valid};
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for both the skid and single-slot builds,
// checked every cycle against a queue model.
module tb_pipe_stage_reg;

  typedef logic [41:0] ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        flush1, in_valid1, in_ready1;
  logic        out_valid1, out_ready1;
  logic [1:0]  in_ctrl1, out_ctrl1, count1;
  logic [39:0] in_data1, out_data1;

  logic        flush0, in_valid0, in_ready0;
  logic        out_valid0, out_ready0;
  logic [1:0]  in_ctrl0, out_ctrl0, count0;
  logic [39:0] in_data0, out_data0;

  int tests = 0;
  int fails = 0;

  ent_t q1[$];
  ent_t q0[$];
  bit   mrdy1 = 1'b1;
  bit   fi1, fo1, fi0, fo0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(40), .SKID(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_ctrl(in_ctrl1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_ctrl(out_ctrl1), .out_data(out_data1),
    .count(count1)
  );

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(40), .SKID(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_ctrl(out_ctrl0), .out_data(out_data0),
    .count(count0)
  );

  task automatic cmp(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Model: FIFO of capacity 2 (skid) or 1 (single slot)
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1.delete();
      q0.delete();
      mrdy1 = 1'b1;
    end else begin
      fi1 = in_valid1 & mrdy1;
      fo1 = (q1.size() != 0) & out_ready1;
      if (flush1) begin
        q1.delete();
        mrdy1 = 1'b1;
      end else begin
        if (fo1) void'(q1.pop_front());
        if (fi1) q1.push_back({in_ctrl1, in_data1});
        mrdy1 = (q1.size() < 2);
      end
      fo0 = (q0.size() != 0) & out_ready0;
      fi0 = in_valid0 & ((q0.size() == 0) | out_ready0);
      if (flush0) begin
        q0.delete();
      end else begin
        if (fo0) void'(q0.pop_front());
        if (fi0) q0.push_back({in_ctrl0, in_data0});
      end
    end
  end

  always @(negedge clk) begin
    cmp("ov1", 64'(out_valid1), 64'(q1.size() != 0));
    cmp("cnt1", 64'(count1), 64'(q1.size()));
    cmp("ir1", 64'(in_ready1), 64'(mrdy1));
    cmp("oc1", 64'(out_ctrl1),
        q1.size() != 0 ? 64'(q1[0][41:40]) : 64'd0);
    if (q1.size() != 0)
      cmp("od1", 64'(out_data1), 64'(q1[0][39:0]));
    cmp("ov0", 64'(out_valid0), 64'(q0.size() != 0));
    cmp("cnt0", 64'(count0), 64'(q0.size()));
    cmp("ir0", 64'(in_ready0),
        64'((q0.size() == 0) | out_ready0));
    cmp("oc0", 64'(out_ctrl0),
        q0.size() != 0 ? 64'(q0[0][41:40]) : 64'd0);
    if (q0.size() != 0)
      cmp("od0", 64'(out_data0), 64'(q0[0][39:0]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flush1 = 0; in_valid1 = 0; out_ready1 = 0;
    in_ctrl1 = 0; in_data1 = 0;
    flush0 = 0; in_valid0 = 0; out_ready0 = 0;
    in_ctrl0 = 0; in_data0 = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_cnt", 64'(count1), 64'd0);
    cmp("rst_ir", 64'(in_ready1), 64'd1);
    cmp("rst_oc", 64'(out_ctrl1), 64'd0);
    reset_n = 1'b1;

    // streaming 0..9
    out_ready1 = 1;
    in_valid1  = 1;
    for (int i = 0; i < 10; i++) begin
      in_data1 = 40'(i);
      in_ctrl1 = 2'(i);
      step();
      cmp("str_data", 64'(out_data1), 64'(i));
      cmp("str_cnt", 64'(count1), 64'd1);
    end
    in_valid1 = 0;
    step();
    cmp("str_drain", 64'(count1), 64'd0);

    // stall fill A,B then drain
    out_ready1 = 0;
    in_valid1  = 1;
    in_ctrl1   = 2'b01;
    in_data1   = 40'hA0_0000_000A;
    step();
    in_ctrl1 = 2'b10;
    in_data1 = 40'hB0_0000_000B;
    step();
    in_valid1 = 0;
    cmp("fill_cnt", 64'(count1), 64'd2);
    cmp("fill_ir", 64'(in_ready1), 64'd0);
    cmp("fill_od", 64'(out_data1), 64'hA0_0000_000A);
    step();
    cmp("hold_od", 64'(out_data1), 64'hA0_0000_000A);
    cmp("hold_oc", 64'(out_ctrl1), 64'd1);
    out_ready1 = 1;
    step();
    cmp("dr_od", 64'(out_data1), 64'hB0_0000_000B);
    cmp("dr_ir", 64'(in_ready1), 64'd1);
    step();
    cmp("dr_cnt", 64'(count1), 64'd0);

    // simultaneous in/out in HALF
    out_ready1 = 0;
    in_valid1  = 1;
    in_ctrl1   = 2'b11;
    in_data1   = 40'h11;
    step();
    in_data1   = 40'h22;
    out_ready1 = 1;
    step();
    in_valid1 = 0;
    cmp("half_od", 64'(out_data1), 64'h22);
    cmp("half_cnt", 64'(count1), 64'd1);
    step();

    // flush while FULL, with C offered
    out_ready1 = 0;
    in_valid1  = 1;
    in_data1   = 40'h33;
    step();
    in_data1 = 40'h44;
    step();
    flush1   = 1;
    in_data1 = 40'hCC;
    step();
    flush1 = 0;
    in_valid1 = 0;
    out_ready1 = 1;
    cmp("fl_cnt", 64'(count1), 64'd0);
    cmp("fl_ov", 64'(out_valid1), 64'd0);
    cmp("fl_oc", 64'(out_ctrl1), 64'd0);
    step();
    cmp("fl_noc", 64'(out_valid1), 64'd0);

    // flush in HALF discards an accepted entry
    in_valid1 = 1;
    in_data1  = 40'h55;
    step();
    flush1   = 1;
    in_data1 = 40'h66;
    step();
    flush1    = 0;
    in_valid1 = 0;
    cmp("flh_ov", 64'(out_valid1), 64'd0);
    step();
    cmp("flh_ov2", 64'(out_valid1), 64'd0);

    // async reset with two entries held
    out_ready1 = 0;
    in_valid1  = 1;
    in_ctrl1   = 2'b11;
    in_data1   = 40'h77;
    step();
    in_data1 = 40'h88;
    step();
    in_valid1 = 0;
    cmp("pre_cnt", 64'(count1), 64'd2);
    reset_n = 1'b0;
    #1;
    cmp("ar_ov", 64'(out_valid1), 64'd0);
    cmp("ar_oc", 64'(out_ctrl1), 64'd0);
    cmp("ar_cnt", 64'(count1), 64'd0);
    cmp("ar_ir", 64'(in_ready1), 64'd1);
    step();
    reset_n = 1'b1;
    in_valid1 = 1;
    in_data1  = 40'h99;
    step();
    in_valid1 = 0;
    cmp("post_od", 64'(out_data1), 64'h99);
    out_ready1 = 1;
    step();

    // single-slot build: stall of a ctrl=11 entry
    out_ready0 = 0;
    in_valid0  = 1;
    in_ctrl0   = 2'b11;
    in_data0   = 40'h5A;
    step();
    in_valid0 = 0;
    cmp("s0_ir", 64'(in_ready0), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("s0_oc", 64'(out_ctrl0), 64'd3);
      cmp("s0_od", 64'(out_data0), 64'h5A);
    end
    out_ready0 = 1;
    #1;
    cmp("s0_ir1", 64'(in_ready0), 64'd1);
    step();
    cmp("s0_drain", 64'(out_ctrl0), 64'd0);
    cmp("s0_cnt", 64'(count0), 64'd0);

    // single-slot streaming
    in_valid0 = 1;
    for (int i = 0; i < 4; i++) begin
      in_ctrl0 = 2'(i);
      in_data0 = 40'(100 + i);
      step();
      cmp("s0_str", 64'(out_data0), 64'(100 + i));
    end
    in_valid0 = 0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
